main_saturation: RTL and testbench
==================================

MAIN_SATURATION -- requirements
Module: main_saturation

Interface
REQ-001 Parameter WIDTH, default 2: bit width of the internal counter.
REQ-002 Parameter MAX_VAL, default 3: saturation ceiling, at most 2^WIDTH-1.
REQ-003 Parameter DEB, default 1: consecutive stable cycles required to accept a button level change, at least 1.
REQ-004 clk  input  1  single system clock; all logic updates on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 btn1  input  1  increment button; active-low (0 = pressed); asynchronous to clk.
REQ-007 btn2  input  1  decrement button; active-low (0 = pressed); asynchronous to clk.
REQ-008 led_r  output  1  active-high; 1 while count == 0.
REQ-009 led_g  output  1  active-high; 1 while count == MAX_VAL.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer (s1, s2) before any other logic sees it.
REQ-011 Debounce, per button: a stable counter increments on every edge where s2 differs from the debounced level.
REQ-012 The stable counter SHALL clear on any edge where s2 equals the debounced level.
REQ-013 When the stable counter equals DEB-1 and s2 still differs, the debounced level SHALL take the value of s2 on that edge, and the stable counter SHALL clear.
REQ-014 A press pulse (combinational) SHALL be high for exactly one cycle: the cycle after the debounced level falls 1->0; a release generates no pulse.
REQ-015 Count SHALL be a WIDTH-bit register, updated only on an edge where a press pulse is high.
REQ-016 Increment pulse alone: count SHALL become count+1 if count < MAX_VAL; otherwise it SHALL hold at MAX_VAL (no wrap).
REQ-017 Decrement pulse alone: count SHALL become count-1 if count > 0; otherwise it SHALL hold at 0 (no wrap).
REQ-018 If increment and decrement pulses are high in the same cycle, count SHALL hold.
REQ-019 A held button SHALL yield exactly one step; there is no auto-repeat.
REQ-020 Latency: count SHALL change on the (DEB+3)th rising edge after the first edge that samples the button low, provided the low level persists; for DEB=1 this is the 4th edge.
REQ-021 led_r and led_g SHALL be decoded combinationally from the count register, so they change in the same cycle as count.
REQ-022 led_r and led_g SHALL never both be 1 when MAX_VAL > 0.

Reset
REQ-023 While rst_n=0 at a rising edge, the following SHALL load:
- synchronizer flops = 1
- debounced levels = 1 (released)
- stable counters = 0
- count = 0
REQ-024 Outputs during and immediately after reset SHALL be led_r=1, led_g=0.
REQ-025 Reset asserted mid-press SHALL discard any partial debounce progress.
REQ-026 A button held low across reset release SHALL be treated as a new press after the REQ-020 latency.

Structure
REQ-027 A shared package SHALL hold default constants WIDTH_DEF=2, MAX_DEF=3 and DEB_DEF=1.
REQ-028 One sub-module, btn_press, SHALL contain synchronizer, debounce and falling-edge pulse logic, instantiated twice (btn1, btn2).
REQ-029 The top level SHALL contain only the saturating counter and the LED decode.

Verification
REQ-030 Reset, btn1=btn2=1 -> count=0, led_r=1, led_g=0.
REQ-031 Three btn1 presses, each low for 4 cycles and high for 4 cycles -> count 1, 2, 3; led_g=1, led_r=0 after the third press.
REQ-032 A fourth btn1 press at count=3 -> count stays 3, led_g stays 1.
REQ-033 From count=3, four btn2 presses -> count 2, 1, 0, 0; led_r=1 after the third press, and the fourth press produces no change.
REQ-034 btn1 and btn2 falling on the same clock edge at count=1 -> count stays 1.
REQ-035 btn1 held low for 50 cycles from count=0 -> count=1 only, with the change on the 4th edge after the low level is first sampled.

Source files
------------

// File: rtl/main_saturation_pkg.sv
// ----------------------------------------------------------------------------
// main_saturation_pkg
// Shared constants and helpers for the saturating button counter.
//   WIDTH_DEF    : default bit width of the counter
//   MAX_DEF      : default saturation ceiling
//   DEB_DEF      : default number of stable cycles needed to accept a level
//   stable_width : bit width of a debounce stable counter for a given DEB
// ----------------------------------------------------------------------------
package main_saturation_pkg;

    localparam int WIDTH_DEF = 2;
    localparam int MAX_DEF   = 3;
    localparam int DEB_DEF   = 1;

    // A stable counter must hold values 0..DEB-1; keep at least one bit so
    // DEB=1 still produces a legal vector.
    function automatic int stable_width(input int deb);
        if (deb > 1) begin
            return $clog2(deb);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/main_saturation_if.sv
// ----------------------------------------------------------------------------
// main_saturation_if
// Groups the button inputs and LED outputs of the saturating counter.
//   btn1  : increment button, active-low, asynchronous
//   btn2  : decrement button, active-low, asynchronous
//   led_r : high while count == 0
//   led_g : high while count == MAX_VAL
// Modports: master drives the buttons (environment), slave is the counter.
// ----------------------------------------------------------------------------
interface main_saturation_if;

    logic btn1;
    logic btn2;
    logic led_r;
    logic led_g;

    modport master (
        output btn1,
        output btn2,
        input  led_r,
        input  led_g
    );

    modport slave (
        input  btn1,
        input  btn2,
        output led_r,
        output led_g
    );

endinterface

// File: rtl/main_saturation_btn_press.sv
// ----------------------------------------------------------------------------
// btn_press
// Turns one raw active-low button into a single-cycle press pulse.
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset
//   btn_i   : raw button level, active-low, asynchronous to clk
//   press_o : high for exactly one cycle after the debounced level falls
// Path: 2-flop synchronizer -> stable-count debounce -> falling-edge detect.
// ----------------------------------------------------------------------------
module btn_press
    import main_saturation_pkg::*;
#(
    parameter int DEB = DEB_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int            SW          = stable_width(DEB);
    localparam logic [SW-1:0] STABLE_LAST = SW'(DEB - 1);

    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [SW-1:0] stable_q;
    logic [SW-1:0] stable_d;

    // Two-flop synchronizer; idles at the released level out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
        end
    end

    // Debounce next state: accept s2 once it has differed for DEB edges.
    always_comb begin
        level_d  = level_q;
        stable_d = {SW{1'b0}};
        if (s2_q != level_q) begin
            if (stable_q == STABLE_LAST) begin
                level_d  = s2_q;
                stable_d = {SW{1'b0}};
            end else begin
                stable_d = stable_q + {{(SW-1){1'b0}}, 1'b1};
            end
        end else begin
            stable_d = {SW{1'b0}};
        end
    end

    // Debounce state and the delayed level used for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            stable_q     <= {SW{1'b0}};
        end else begin
            level_q      <= level_d;
            level_prev_q <= level_q;
            stable_q     <= stable_d;
        end
    end

    // Pulse only on 1->0 of the debounced level, so a held button or a
    // release never produces a further step.
    assign press_o = level_prev_q & ~level_q;

endmodule

// File: rtl/main_saturation.sv
// ----------------------------------------------------------------------------
// main_saturation
// Saturating up/down counter driven by two debounced push buttons.
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : slave modport carrying btn1/btn2 in and led_r/led_g out
// Parameters: WIDTH (counter bits), MAX_VAL (ceiling), DEB (debounce depth).
// LEDs are decoded straight from the count register so they track it with
// no extra cycle of delay.
// ----------------------------------------------------------------------------
module main_saturation
    import main_saturation_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MAX_VAL = MAX_DEF,
    parameter int DEB     = DEB_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    main_saturation_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             inc_s;
    logic             dec_s;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    btn_press #(.DEB(DEB)) u_btn_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.btn1),
        .press_o (inc_s)
    );

    btn_press #(.DEB(DEB)) u_btn_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.btn2),
        .press_o (dec_s)
    );

    // Saturating step; simultaneous inc and dec cancel out.
    always_comb begin
        count_d = count_q;
        case ({inc_s, dec_s})
            2'b10: begin
                if (count_q < MAX_C) begin
                    count_d = count_q + ONE_C;
                end else begin
                    count_d = count_q;
                end
            end
            2'b01: begin
                if (count_q > ZERO_C) begin
                    count_d = count_q - ONE_C;
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= ZERO_C;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.led_r = (count_q == ZERO_C);
    assign bus.led_g = (count_q == MAX_C);

endmodule

// File: tb/tb_main_saturation.sv
// ----------------------------------------------------------------------------
// tb_main_saturation
// Directed bench for main_saturation with default parameters. Expected
// count/LED values come from a small saturating model and travel through a
// scoreboard queue from the stimulus point to the compare point.
// ----------------------------------------------------------------------------
module tb_main_saturation;
    import main_saturation_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    main_saturation_if bus ();

    main_saturation #(
        .WIDTH   (WIDTH_DEF),
        .MAX_VAL (MAX_DEF),
        .DEB     (DEB_DEF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int   cnt;
        logic r;
        logic g;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   model   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_model(input bit inc, input bit dec);
        if (inc && !dec && model < MAX_DEF) begin
            model++;
        end else if (dec && !inc && model > 0) begin
            model--;
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.cnt = model;
        e.r   = (model == 0);
        e.g   = (model == MAX_DEF);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            n_total--;
            e = sb.pop_front();
            chk({tag, "_count"}, 32'(dut.count_q), 32'(e.cnt));
            chk({tag, "_led_r"}, 32'(bus.led_r), 32'(e.r));
            chk({tag, "_led_g"}, 32'(bus.led_g), 32'(e.g));
        end
    endtask

    // Press one or both buttons from a negedge: low for lo cycles (checked at
    // the end of the low phase, i.e. just after the 4th edge), then high.
    task automatic press(input bit b1, input bit b2, input int lo, input int hi, input string tag);
        bus.btn1 = ~b1;
        bus.btn2 = ~b2;
        apply_model(b1, b2);
        push_model();
        repeat (lo) @(negedge clk);
        pop_check(tag);
        bus.btn1 = 1'b1;
        bus.btn2 = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.btn1 = 1'b1;
        bus.btn2 = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        push_model();
        pop_check("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_model();
        pop_check("post_reset");

        // Three increments, then one against the ceiling.
        for (int i = 1; i <= 3; i++) begin
            press(1'b1, 1'b0, 4, 4, $sformatf("inc%0d", i));
        end
        press(1'b1, 1'b0, 4, 4, "inc_sat");

        // Four decrements, the last against the floor.
        for (int i = 1; i <= 4; i++) begin
            press(1'b0, 1'b1, 4, 4, $sformatf("dec%0d", i));
        end

        // Up to 1, then both buttons together must hold.
        press(1'b1, 1'b0, 4, 4, "inc_to1");
        press(1'b1, 1'b1, 4, 4, "both");
        press(1'b0, 1'b1, 4, 4, "dec_to0");

        // Long hold: one step only, landing on the 4th edge.
        bus.btn1 = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 4) begin
                apply_model(1'b1, 1'b0);
            end
            push_model();
            pop_check($sformatf("hold_e%0d", i));
        end
        bus.btn1 = 1'b1;
        repeat (6) @(negedge clk);

        // Reset hits on the edge where the debounce would have accepted the
        // press; the still-held button must then count as a fresh press.
        bus.btn1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model = 0;
        push_model();
        pop_check("mid_reset");
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 4) begin
                apply_model(1'b1, 1'b0);
            end
            push_model();
            pop_check($sformatf("after_rst_e%0d", i));
        end
        bus.btn1 = 1'b1;
        repeat (6) @(negedge clk);
        push_model();
        pop_check("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
